// File: rtl/carregador_programa_pkg.sv
// Shared constants and FSM encoding for the instruction-memory program loader.
package carregador_programa_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 16;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_VERIFY_REQ  = 3'd2,
    S_VERIFY_WAIT = 3'd3,
    S_DONE        = 3'd4,
    S_ERROR       = 3'd5
  } estado_t;
endpackage

// File: rtl/carregador_programa_soma.sv
// Modular (2**W) accumulator with synchronous clear and enable.
module soma_verificacao #(
  parameter int W = carregador_programa_pkg::DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] soma
);
  always_ff @(posedge clk) begin
    if (!rst_n)   soma <= '0;
    else if (clr) soma <= '0;
    else if (en)  soma <= soma + din;
  end
endmodule

// File: rtl/carregador_programa.sv
// Program loader: streams host words into instruction memory, reads them back,
// and releases the CPU from halt only when the read-back sum matches.
module carregador_programa #(
  parameter int ADDR_WIDTH = carregador_programa_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = carregador_programa_pkg::DATA_WIDTH,
  parameter int DEPTH      = carregador_programa_pkg::DEPTH,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  cpu_halt,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [DATA_WIDTH-1:0] checksum
);
  import carregador_programa_pkg::*;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH:0] ULTIMO_IDX = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [CW-1:0]       ESPERA_FIM = CW'(RD_LAT-1);

  estado_t               estado;
  logic                  ultimo_visto;
  logic [ADDR_WIDTH:0]   idx, idx_nxt;
  logic [CW-1:0]         espera;
  logic                  beat, limpa, leitura_en;
  logic [DATA_WIDTH-1:0] soma_lida, soma_lida_nxt;

  // Ready drops once the final word is accepted so its write cycle cannot take another beat.
  assign word_ready    = (estado == S_LOAD) && !ultimo_visto;
  assign beat          = word_valid && word_ready;
  assign limpa         = (estado inside {S_IDLE, S_DONE, S_ERROR}) && start;
  assign leitura_en    = (estado == S_VERIFY_WAIT) && (espera == ESPERA_FIM);
  assign idx_nxt       = idx + 1'b1;
  assign soma_lida_nxt = soma_lida + mem_q;

  soma_verificacao #(.W(DATA_WIDTH)) u_soma_escrita (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .clr  (limpa),
    .en   (beat),
    .din  (word_data),
    .soma (checksum)
  );

  soma_verificacao #(.W(DATA_WIDTH)) u_soma_leitura (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .clr  (limpa),
    .en   (leitura_en),
    .din  (mem_q),
    .soma (soma_lida)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      estado       <= S_IDLE;
      ultimo_visto <= 1'b0;
      idx          <= '0;
      espera       <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      cpu_halt     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (estado)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            estado       <= S_LOAD;
            ultimo_visto <= 1'b0;
            words_loaded <= '0;
            mem_address  <= '0;
            cpu_halt     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ultimo_visto) begin
            estado      <= S_VERIFY_REQ;
            idx         <= '0;
            mem_address <= '0;
          end else if (beat) begin
            mem_wren     <= 1'b1;
            mem_address  <= words_loaded[ADDR_WIDTH-1:0];
            mem_data     <= word_data;
            words_loaded <= words_loaded + 1'b1;
            if (word_last || words_loaded == ULTIMO_IDX) ultimo_visto <= 1'b1;
          end
        end
        S_VERIFY_REQ: begin
          estado <= S_VERIFY_WAIT;
          espera <= '0;
        end
        S_VERIFY_WAIT: begin
          if (!leitura_en) begin
            espera <= espera + 1'b1;
          end else if (idx_nxt == words_loaded) begin
            // Compare using the sum including the word arriving this cycle.
            if (soma_lida_nxt == checksum) begin
              estado    <= S_DONE;
              cpu_halt  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              estado     <= S_ERROR;
              load_error <= 1'b1;
            end
          end else begin
            idx         <= idx_nxt;
            mem_address <= idx_nxt[ADDR_WIDTH-1:0];
            estado      <= S_VERIFY_REQ;
          end
        end
        default: estado <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench: memory model, transaction-level expectation model and per-cycle compare.
module tb_carregador_programa;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N = 1'b0, start = 1'b0, word_valid = 1'b0, word_last = 1'b0;
  logic [DW-1:0] word_data = '0, mem_q = '0, mem_data;
  logic          word_ready, mem_wren, cpu_halt, load_done, load_error;
  logic [AW-1:0] mem_address;
  logic [AW:0]   words_loaded;
  logic [DW-1:0] checksum;

  always #10 CLOCK_50 = ~CLOCK_50;

  carregador_programa dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .cpu_halt(cpu_halt),
    .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  // Synchronous memory, one-cycle read latency, optional bit-0 flip on address 1.
  logic [DW-1:0] tb_mem [16];
  bit corrupt = 1'b0;
  always @(posedge CLOCK_50) begin
    if (mem_wren) tb_mem[mem_address] <= mem_data;
    mem_q <= tb_mem[mem_address] ^ ((corrupt && mem_address == 4'd1) ? 16'h0001 : 16'h0000);
  end

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Expectation model: load phase tracks accepted words; verify is 2 cycles per word.
  typedef enum {M_IDLE, M_LOAD, M_VERIFY, M_DONE, M_ERROR} mfase_t;
  mfase_t        m_fase = M_IDLE;
  bit            m_live = 1'b0, m_last = 1'b0, m_wr = 1'b0, m_rst = 1'b0;
  int            m_n = 0, m_v = 0, wren_cnt = 0;
  logic [15:0]   m_sum = '0, m_wd = '0;
  logic [3:0]    m_wa = '0;
  bit            s_rst, s_start, s_v, s_l;
  logic [15:0]   s_d;

  always @(posedge CLOCK_50) begin
    s_rst = RESET_N; s_start = start; s_v = word_valid; s_l = word_last; s_d = word_data;
    m_wr = 1'b0;
    m_rst = 1'b0;
    if (!s_rst) begin
      m_live = 1'b1; m_rst = 1'b1; m_fase = M_IDLE;
      m_n = 0; m_sum = '0; m_last = 1'b0;
    end else begin
      case (m_fase)
        M_IDLE, M_DONE, M_ERROR:
          if (s_start) begin m_fase = M_LOAD; m_n = 0; m_sum = '0; m_last = 1'b0; end
        M_LOAD:
          if (m_last) begin
            m_fase = M_VERIFY; m_v = 0;
          end else if (s_v) begin
            m_wr = 1'b1; m_wa = m_n[3:0]; m_wd = s_d;
            m_n++; m_sum = m_sum + s_d;
            if (s_l || m_n == 16) m_last = 1'b1;
          end
        M_VERIFY: begin
          m_v++;
          if (m_v == 2 * m_n) m_fase = (corrupt && m_n >= 2) ? M_ERROR : M_DONE;
        end
        default: ;
      endcase
    end
    #1;
    if (mem_wren) wren_cnt++;
    if (m_live) begin
      chk("word_ready", word_ready, (m_fase == M_LOAD) && !m_last);
      chk("mem_wren", mem_wren, m_wr);
      chk("cpu_halt", cpu_halt, m_fase != M_DONE);
      chk("load_done", load_done, m_fase == M_DONE);
      chk("load_error", load_error, m_fase == M_ERROR);
      chk("words_loaded", words_loaded, m_n);
      chk("checksum", checksum, m_sum);
      if (m_wr) begin
        chk("wr_address", mem_address, m_wa);
        chk("wr_data", mem_data, m_wd);
      end
      if (m_fase == M_VERIFY) chk("rd_address", mem_address, m_v / 2);
      if (m_rst) begin
        chk("rst_address", mem_address, 0);
        chk("rst_data", mem_data, 0);
      end
    end
  end

  task automatic do_start();
    @(negedge CLOCK_50) start = 1'b1;
    @(negedge CLOCK_50) start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit l, input bit v);
    word_valid = v; word_data = d; word_last = l;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_end(output int k);
    word_valid = 1'b0; word_last = 1'b0;
    k = 0;
    while (!(load_done || load_error) && k < 200) begin
      @(posedge CLOCK_50); #1; k++;
    end
    chk("finished_in_time", load_done | load_error, 1);
    @(negedge CLOCK_50);
  endtask

  int k;
  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = '0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    chk("reset_halt", cpu_halt, 1);
    chk("reset_wl", words_loaded, 0);

    // Three-word load with explicit last.
    do_start();
    send(16'h1234, 0, 1); send(16'h0ABC, 0, 1); send(16'h6021, 1, 1);
    wait_end(k);
    chk("t1_latency", k, 7);  // write cycle + 6 verify cycles
    chk("t1_checksum", checksum, 16'h7D11);
    chk("t1_wl", words_loaded, 3);
    chk("t1_done", load_done, 1);
    chk("t1_halt", cpu_halt, 0);
    chk("t1_mem2", tb_mem[2], 16'h6021);

    // Full memory, implicit last.
    do_start();
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 0, 1);
    wait_end(k);
    chk("t2_latency", k, 33);
    chk("t2_wl", words_loaded, 16);
    chk("t2_done", load_done, 1);
    chk("t2_mem15", tb_mem[15], 16'h010F);

    // Read-back corruption, then a clean reload.
    corrupt = 1'b1;
    do_start();
    send(16'h1111, 0, 1); send(16'h2222, 0, 1); send(16'h3333, 1, 1);
    wait_end(k);
    chk("t3_error", load_error, 1);
    chk("t3_halt", cpu_halt, 1);
    chk("t3_done", load_done, 0);
    corrupt = 1'b0;
    do_start();
    chk("t3_err_cleared", load_error, 0);
    send(16'h1111, 0, 1); send(16'h2222, 0, 1); send(16'h3333, 1, 1);
    wait_end(k);
    chk("t3_reload_done", load_done, 1);

    // Gaps in word_valid.
    do_start();
    wren_cnt = 0;
    send(16'hA001, 0, 1); send(16'hDEAD, 0, 0); send(16'hBEEF, 0, 0);
    send(16'hA002, 0, 1); send(16'hA003, 1, 1);
    wait_end(k);
    chk("t4_wren_pulses", wren_cnt, 3);
    chk("t4_wl", words_loaded, 3);
    chk("t4_mem1", tb_mem[1], 16'hA002);

    // Checksum wrap.
    do_start();
    send(16'hFFFF, 0, 1); send(16'h0002, 1, 1);
    wait_end(k);
    chk("t5_checksum", checksum, 16'h0001);
    chk("t5_done", load_done, 1);

    // Reset in the middle of a load.
    do_start();
    send(16'h5001, 0, 1); send(16'h5002, 0, 1);
    RESET_N = 1'b0;
    send(16'h5003, 0, 1);
    RESET_N = 1'b1;
    chk("t6_wren", mem_wren, 0);
    chk("t6_wl", words_loaded, 0);
    chk("t6_halt", cpu_halt, 1);
    wren_cnt = 0;
    send(16'h5004, 0, 1); send(16'h5005, 1, 1);
    word_valid = 1'b0; word_last = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("t6_no_writes", wren_cnt, 0);
    chk("t6_mem2_untouched", tb_mem[2], 16'hA003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
Program loader on the write side of the processor's 16-bit instruction memory. The CPU core only reads this memory.
- Accepts instruction words from a host stream through a valid/ready handshake.
- Writes the words to consecutive addresses starting at 0, then reads them back and checks a 16-bit checksum.
- Holds the CPU in halt until a load verifies cleanly.

Parameters:
ADDR_WIDTH, 4, instruction memory address width (matches the 4-bit PC)
DATA_WIDTH, 16, instruction word width
DEPTH, 16, maximum words per load; must equal 2**ADDR_WIDTH
RD_LAT, 1, memory read latency in cycles, from address presented to mem_q valid (synchronous ROM/RAM)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
RESET_N  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a new load
word_valid  in  1  host word present
word_data  in  DATA_WIDTH  instruction word
word_last  in  1  marks the final word of the program
word_ready  out  1  loader accepts a word this cycle
mem_address  out  ADDR_WIDTH  memory address for both write and read-back
mem_data  out  DATA_WIDTH  memory write data
mem_wren  out  1  memory write enable
mem_q  in  DATA_WIDTH  memory read data
cpu_halt  out  1  stalls PC and register writes when 1
load_done  out  1  load verified; level signal
load_error  out  1  checksum mismatch; level signal
words_loaded  out  ADDR_WIDTH+1  count of words written in the current/last load
checksum  out  DATA_WIDTH  running sum of the words written

Behaviour:
- Reset (RESET_N=0 at an edge): state IDLE; cpu_halt=1; every other output 0; counters and sums cleared. Memory contents are not touched. Reset mid-load aborts immediately, with no further writes.
- States: IDLE, LOAD, VERIFY_REQ, VERIFY_WAIT, DONE, ERROR.
- IDLE, DONE and ERROR:
  - start=1 → LOAD.
  - On entry to LOAD: clear words_loaded, checksum and the read sum; cpu_halt=1; load_done=0; load_error=0.
  - word_ready=0 in these states; word_valid is ignored.
- LOAD:
  - word_ready=1 combinationally while in LOAD.
  - A beat is word_valid & word_ready at an edge.
  - The cycle after a beat: mem_wren=1, mem_address=previous words_loaded, mem_data=word. words_loaded+1. checksum += word, mod 2**16.
  - mem_wren is 0 in every cycle that does not follow a beat. Gaps in word_valid are allowed.
  - Exit condition: a beat with word_last=1, or the DEPTH-th beat (implicit last). The word_last beat is always written; LOAD → VERIFY_REQ after that write cycle.
  - start during LOAD is ignored. A load always contains at least 1 word.
- VERIFY_REQ:
  - Drives mem_address=i with mem_wren=0, for i = 0..words_loaded-1, then → VERIFY_WAIT.
- VERIFY_WAIT:
  - Waits RD_LAT cycles, then adds mem_q to the read sum (mod 2**16) and increments i.
  - If i = words_loaded: compare the read sum with checksum.
    - Equal → DONE: load_done=1, cpu_halt=0.
    - Not equal → ERROR: load_error=1, cpu_halt=1.
  - Otherwise → VERIFY_REQ.
- Verify duration: words_loaded*(RD_LAT+1) cycles. Outputs are registered, except word_ready.
- words_loaded and checksum hold their values in DONE and ERROR until the next start.

Decomposition:
- Shared package: state enum (6 states, 3-bit encoding); constants DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=16.
- One natural sub-module, soma_verificacao: mod-2**16 accumulator with clear and enable. Instantiated twice, once for the write checksum and once for the read-back sum.

Test Plan:
- Load 0x1234, 0x0ABC, 0x6021, with word_last on the third word; memory model correct → writes to addresses 0, 1, 2; checksum=0x7D11; words_loaded=3; DONE after 6 verify cycles (RD_LAT=1); cpu_halt falls to 0.
- 16 beats with word_last never asserted → implicit last after the write to address 15; words_loaded=16; DONE.
- Memory model flips bit 0 of address 1 on read-back → ERROR; load_error=1; cpu_halt stays 1. A new start clears load_error and reloads.
- word_valid toggled 1,0,0,1,1 across 3 words → exactly 3 mem_wren pulses, each one cycle after its beat; no duplicate writes.
- Words 0xFFFF and 0x0002 → checksum wraps to 0x0001; DONE.
- RESET_N=0 asserted after the 2nd of 5 beats → next cycle IDLE, mem_wren=0, words_loaded=0, cpu_halt=1; later word_valid beats are ignored.
